// File: rtl/voltmeter_pkg.sv
// Shared definitions for the voltmeter ADC front end: sequencer states,
// GAP next-phase tags and default phase timings.
package voltmeter_pkg;

   // Conversion sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_AZ    = 3'd1,
      ST_GAP   = 3'd2,
      ST_INT   = 3'd3,
      ST_DEINT = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // Phase that follows a GAP cycle.
   typedef enum logic [1:0] {
      TAG_IDLE  = 2'd0,
      TAG_INT   = 2'd1,
      TAG_DEINT = 2'd2
   } gap_tag_e;

   // Default phase lengths in clk cycles.
   localparam int DEF_T_AZ        = 1000;
   localparam int DEF_T_INT       = 10000;
   localparam int DEF_T_DEINT_MAX = 20000;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous input.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dual_slope_ctrl.sv
// Conversion sequencer for the dual-slope integrating ADC: auto-zero,
// fixed-time integrate, reference de-integrate, result hand-off.
//
// Handshake: start_i is a request sampled only while idle (busy_o=0);
// requests while busy_o=1 are dropped, not queued. valid_o is a one-cycle
// pulse with no back-pressure: result_o/pol_o/ovr_o change on the same edge
// that raises valid_o and then hold until the next valid_o (or reset).
module dual_slope_ctrl
   import voltmeter_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int T_AZ        = DEF_T_AZ,
   parameter int T_INT       = DEF_T_INT,
   parameter int T_DEINT_MAX = DEF_T_DEINT_MAX,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             cmp_i,
   output logic             az_o,
   output logic             int_o,
   output logic             ref_pos_o,
   output logic             ref_neg_o,
   output logic             busy_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] result_o,
   output logic             pol_o,
   output logic             ovr_o
);

   localparam logic [CNT_W-1:0] AZ_LOAD    = CNT_W'(T_AZ - 1);
   localparam logic [CNT_W-1:0] INT_LOAD   = CNT_W'(T_INT - 1);
   localparam logic [CNT_W-1:0] DEINT_LAST = CNT_W'(T_DEINT_MAX - 1);
   localparam logic [CNT_W-1:0] DEINT_OVR  = CNT_W'(T_DEINT_MAX);

   logic cmp_s;

   state_e           state_q, state_d;
   gap_tag_e         tag_q, tag_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pol_int_q, pol_int_d;
   logic [CNT_W-1:0] result_q, result_d;
   logic             pol_q, pol_d;
   logic             ovr_q, ovr_d;
   logic             valid_q, valid_d;
   logic             az_q, az_d;
   logic             int_q, int_d;
   logic             ref_pos_q, ref_pos_d;
   logic             ref_neg_q, ref_neg_d;
   logic             busy_q, busy_d;

   sync_ff #(
      .STAGES(SYNC_STAGES)
   ) u_cmp_sync (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .d_i  (cmp_i),
      .q_o  (cmp_s)
   );

   // Next-state, phase timer, de-integrate counter and registered output decode.
   always_comb begin
      state_d   = state_q;
      tag_d     = tag_q;
      timer_d   = timer_q;
      cnt_d     = cnt_q;
      pol_int_d = pol_int_q;
      result_d  = result_q;
      pol_d     = pol_q;
      ovr_d     = ovr_q;
      valid_d   = 1'b0;

      if (state_q == ST_IDLE) begin
         // abort_i takes priority over start_i while idle.
         if (start_i && !abort_i) begin
            state_d = ST_AZ;
            timer_d = AZ_LOAD;
         end
      end else if (abort_i) begin
         // Open every switch for one cycle before returning to idle.
         state_d = ST_GAP;
         tag_d   = TAG_IDLE;
      end else begin
         case (state_q)
            ST_AZ: begin
               if (timer_q == '0) begin
                  state_d = ST_GAP;
                  tag_d   = TAG_INT;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            ST_GAP: begin
               case (tag_q)
                  TAG_INT: begin
                     state_d = ST_INT;
                     timer_d = INT_LOAD;
                  end
                  TAG_DEINT: begin
                     state_d = ST_DEINT;
                     cnt_d   = '0;
                  end
                  default: state_d = ST_IDLE;
               endcase
            end
            ST_INT: begin
               if (timer_q == '0) begin
                  // The comparator at the end of integration gives input polarity.
                  pol_int_d = cmp_s;
                  state_d   = ST_GAP;
                  tag_d     = TAG_DEINT;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            ST_DEINT: begin
               // A zero crossing is checked first so it beats a simultaneous timeout.
               if (cmp_s != pol_int_q) begin
                  result_d = cnt_q;
                  ovr_d    = 1'b0;
                  pol_d    = pol_int_q;
                  valid_d  = 1'b1;
                  state_d  = ST_DONE;
               end else if (cnt_q == DEINT_LAST) begin
                  result_d = DEINT_OVR;
                  ovr_d    = 1'b1;
                  pol_d    = pol_int_q;
                  valid_d  = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end

      // Switch drives are decoded from the next state so they register in step with it.
      az_d      = (state_d == ST_IDLE) || (state_d == ST_AZ);
      int_d     = (state_d == ST_INT);
      ref_pos_d = (state_d == ST_DEINT) && pol_int_d;
      ref_neg_d = (state_d == ST_DEINT) && !pol_int_d;
      busy_d    = (state_d != ST_IDLE);
   end

   // State, counters, result and switch registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         tag_q     <= TAG_IDLE;
         timer_q   <= '0;
         cnt_q     <= '0;
         pol_int_q <= 1'b0;
         result_q  <= '0;
         pol_q     <= 1'b0;
         ovr_q     <= 1'b0;
         valid_q   <= 1'b0;
         az_q      <= 1'b1;
         int_q     <= 1'b0;
         ref_pos_q <= 1'b0;
         ref_neg_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tag_q     <= tag_d;
         timer_q   <= timer_d;
         cnt_q     <= cnt_d;
         pol_int_q <= pol_int_d;
         result_q  <= result_d;
         pol_q     <= pol_d;
         ovr_q     <= ovr_d;
         valid_q   <= valid_d;
         az_q      <= az_d;
         int_q     <= int_d;
         ref_pos_q <= ref_pos_d;
         ref_neg_q <= ref_neg_d;
         busy_q    <= busy_d;
      end
   end

   assign az_o      = az_q;
   assign int_o     = int_q;
   assign ref_pos_o = ref_pos_q;
   assign ref_neg_o = ref_neg_q;
   assign busy_o    = busy_q;
   assign valid_o   = valid_q;
   assign result_o  = result_q;
   assign pol_o     = pol_q;
   assign ovr_o     = ovr_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Testbench for dual_slope_ctrl with short phase timings. Each conversion is
// predicted as a cycle timeline from the start edge and compared every cycle.
module tb_dual_slope_ctrl;

   localparam int CNT_W       = 16;
   localparam int T_AZ        = 4;
   localparam int T_INT       = 8;
   localparam int T_DEINT_MAX = 20;
   localparam int SYNC        = 2;
   localparam int NEVER       = 1000;
   localparam int C0          = T_AZ + T_INT + 2;   // first DEINT cycle after start edge

   logic             clk = 1'b0;
   logic             rst_i, start_i, abort_i, cmp_i;
   logic             az_o, int_o, ref_pos_o, ref_neg_o, busy_o, valid_o;
   logic [CNT_W-1:0] result_o;
   logic             pol_o, ovr_o;

   int               checks = 0;
   int               errors = 0;
   logic [CNT_W-1:0] exp_result;
   logic             exp_pol, exp_ovr;
   bit               sched[64];

   dual_slope_ctrl #(
      .CNT_W      (CNT_W),
      .T_AZ       (T_AZ),
      .T_INT      (T_INT),
      .T_DEINT_MAX(T_DEINT_MAX),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .abort_i  (abort_i),
      .cmp_i    (cmp_i),
      .az_o     (az_o),
      .int_o    (int_o),
      .ref_pos_o(ref_pos_o),
      .ref_neg_o(ref_neg_o),
      .busy_o   (busy_o),
      .valid_o  (valid_o),
      .result_o (result_o),
      .pol_o    (pol_o),
      .ovr_o    (ovr_o)
   );

   always #5 clk = ~clk;

   // One conversion. cycle c = state after the c-th rising edge, edge 0 samples start_i.
   // cmp_i driven at edge m is seen by the sequencer's decision at edge m+SYNC.
   task automatic run_conv(input string name, input bit neg, input int cross_off,
                           input int abort_at, input int rst_at, input bit hold_start);
      int         drop_idx, d, res, n, c_done;
      bit         pol, ovr, lvl;
      logic [5:0] exp_v, act_v;
      logic [3:0] prev_sw;
      lvl      = !neg;
      drop_idx = (cross_off == NEVER) ? NEVER : C0 + cross_off;
      for (int i = 0; i < 64; i++)
         sched[i] = (i < T_AZ) ? bit'($urandom_range(0, 1)) : ((i < drop_idx) ? lvl : !lvl);
      pol = sched[T_AZ + T_INT + 1 - SYNC];
      res = 0; ovr = 1'b0; d = 0;
      for (int k = 0; k < T_DEINT_MAX; k++) begin
         if (sched[T_AZ + T_INT + 3 + k - SYNC] != pol) begin
            res = k; d = k + 1;
            break;
         end
         if (k == T_DEINT_MAX - 1) begin
            res = T_DEINT_MAX; ovr = 1'b1; d = T_DEINT_MAX;
         end
      end
      c_done = C0 + d;
      n = (rst_at >= 0) ? rst_at + 3 : ((abort_at >= 0) ? abort_at + 3 : c_done + 3);
      prev_sw = 4'b1000;
      for (int c = 0; c < n; c++) begin
         start_i = (c == 0) || (hold_start && c <= rst_at);
         abort_i = (c == abort_at);
         rst_i   = (c == rst_at);
         cmp_i   = sched[c];
         @(posedge clk);
         @(negedge clk);
         if (rst_at >= 0 && c >= rst_at) begin
            exp_v = 6'b1000_00;
            if (c == rst_at) begin
               exp_result = '0; exp_pol = 1'b0; exp_ovr = 1'b0;
            end
         end else if (abort_at >= 0 && c >= abort_at) begin
            exp_v = (c == abort_at) ? 6'b0000_10 : 6'b1000_00;
         end else if (c < T_AZ) exp_v = 6'b1000_10;
         else if (c == T_AZ) exp_v = 6'b0000_10;
         else if (c <= T_AZ + T_INT) exp_v = 6'b0100_10;
         else if (c == T_AZ + T_INT + 1) exp_v = 6'b0000_10;
         else if (c < c_done) exp_v = {2'b00, pol, !pol, 2'b10};
         else if (c == c_done) begin
            exp_v = 6'b0000_11;
            exp_result = CNT_W'(res); exp_pol = pol; exp_ovr = ovr;
         end else exp_v = 6'b1000_00;
         act_v = {az_o, int_o, ref_pos_o, ref_neg_o, busy_o, valid_o};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d az/int/rp/rn/busy/valid got %b want %b", name, c, act_v, exp_v);
         end
         checks++;
         if ({result_o, pol_o, ovr_o} !== {exp_result, exp_pol, exp_ovr}) begin
            errors++;
            $display("FAIL %s cycle %0d result/pol/ovr got %0d/%b/%b want %0d/%b/%b",
                     name, c, result_o, pol_o, ovr_o, exp_result, exp_pol, exp_ovr);
         end
         checks++;
         if ($countones(act_v[5:2]) > 1) begin
            errors++;
            $display("FAIL %s cycle %0d switch_onehot got %b want at most one set", name, c, act_v[5:2]);
         end
         if (!(rst_at >= 0 && c == rst_at)) begin
            checks++;
            if (prev_sw != 4'b0 && act_v[5:2] != 4'b0 && act_v[5:2] != prev_sw) begin
               errors++;
               $display("FAIL %s cycle %0d break_before_make got %b after %b want a gap",
                        name, c, act_v[5:2], prev_sw);
            end
         end
         prev_sw = act_v[5:2];
      end
      start_i = 1'b0; abort_i = 1'b0; rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; cmp_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      exp_result = '0; exp_pol = 1'b0; exp_ovr = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({az_o, int_o, ref_pos_o, ref_neg_o, busy_o, valid_o} !== 6'b1000_00) begin
            errors++;
            $display("FAIL reset_idle cycle %0d got %b want 100000", c,
                     {az_o, int_o, ref_pos_o, ref_neg_o, busy_o, valid_o});
         end
         checks++;
         if ({result_o, pol_o, ovr_o} !== '0) begin
            errors++;
            $display("FAIL reset_result cycle %0d got %0d/%b/%b want 0/0/0", c, result_o, pol_o, ovr_o);
         end
      end
   endtask

   task automatic test_start_abort_idle();
      start_i = 1'b1; abort_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0; abort_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if ({az_o, busy_o, valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL start_abort_idle cycle %0d az/busy/valid got %b want 100", c,
                     {az_o, busy_o, valid_o});
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_positive();
      run_conv("positive", 1'b0, 6, -1, -1, 1'b0);
   endtask

   task automatic test_negative();
      run_conv("negative", 1'b1, 4, -1, -1, 1'b0);
   endtask

   task automatic test_overrange();
      run_conv("ovr_pos", 1'b0, NEVER, -1, -1, 1'b0);
      run_conv("ovr_neg", 1'b1, NEVER, -1, -1, 1'b0);
   endtask

   task automatic test_boundaries();
      run_conv("cross_first", 1'b0, -1, -1, -1, 1'b0);
      run_conv("cross_at_timeout", 1'b1, T_DEINT_MAX - 2, -1, -1, 1'b0);
      run_conv("cross_after_timeout", 1'b0, T_DEINT_MAX - 1, -1, -1, 1'b0);
   endtask

   task automatic test_abort();
      run_conv("abort_int3", 1'b0, 6, T_AZ + 4, -1, 1'b0);
      run_conv("abort_deint", 1'b1, 8, C0 + 3, -1, 1'b0);
      test_start_abort_idle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         run_conv("random", bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 22)) - 1,
                  -1, -1, 1'b0);
      end
   endtask

   task automatic test_hold_reset();
      run_conv("hold_start_rst", 1'b0, 12, -1, C0 + 5, 1'b1);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; cmp_i = 1'b0;
      exp_result = '0; exp_pol = 1'b0; exp_ovr = 1'b0;
      @(negedge clk);
      test_reset();
      test_positive();
      test_negative();
      test_overrange();
      test_boundaries();
      test_abort();
      test_back_to_back();
      test_hold_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
